count_sequencer: RTL and testbench

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/count_seq_pkg.sv | 17 +
 rtl/updown_counter.sv | 38 +++
 rtl/count_sequencer.sv | 161 ++++++++++++++++
 tb/tb_count_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count sequencer: FSM state encoding,
// direction codes and default widths.
package count_seq_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_REP_W = 4;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : count_seq_pkg

// File: rtl/updown_counter.sv
// Loadable WIDTH-bit up/down counter. Load wins over enable; the count
// wraps modulo 2^WIDTH in both directions.
module updown_counter
   import count_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             dir,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_r;

   // Counter register: async clear, then load, then step in the chosen direction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_r <= '0;
      end else if (load) begin
         q_r <= load_val;
      end else if (en) begin
         if (dir == DIR_UP) begin
            q_r <= q_r + WIDTH'(1);
         end else begin
            q_r <= q_r - WIDTH'(1);
         end
      end else begin
         q_r <= q_r;
      end
   end

   assign q = q_r;

endmodule : updown_counter

// File: rtl/count_sequencer.sv
// Command-driven count sequencer. A command supplies direction, start, end
// and pass count; the block counts start..end once per pass, pulsing wrap at
// the end of each pass and done after the last one. Pause freezes the run,
// abort drops straight back to idle without a done pulse.
module count_sequencer
   import count_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int REP_W = DEF_REP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [WIDTH-1:0] cmd_start,
   input  logic [WIDTH-1:0] cmd_end,
   input  logic [REP_W-1:0] cmd_reps,
   input  logic             pause,
   input  logic             abort,
   output logic [WIDTH-1:0] cnt_out,
   output logic             busy,
   output logic             wrap,
   output logic             done
);

   state_t           state_r;
   state_t           state_nx_s;

   logic             dir_r;
   logic [WIDTH-1:0] start_r;
   logic [WIDTH-1:0] end_r;
   logic [REP_W-1:0] reps_left_r;

   logic             accept_s;
   logic             reps_dec_s;
   logic             cnt_load_s;
   logic [WIDTH-1:0] cnt_load_val_s;
   logic             cnt_en_s;
   logic             wrap_s;
   logic [WIDTH-1:0] cnt_s;
   logic [REP_W-1:0] reps_norm_s;

   // A zero pass count is treated as a single pass.
   always_comb begin
      if (cmd_reps == '0) begin
         reps_norm_s = REP_W'(1);
      end else begin
         reps_norm_s = cmd_reps;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state and datapath control: accept in IDLE, step/reload in RUN,
   // one-cycle DONE. Abort outranks pause, pause outranks counting.
   always_comb begin
      state_nx_s     = state_r;
      accept_s       = 1'b0;
      reps_dec_s     = 1'b0;
      cnt_load_s     = 1'b0;
      cnt_load_val_s = start_r;
      cnt_en_s       = 1'b0;
      wrap_s         = 1'b0;
      case (state_r)
         IDLE: begin
            if (cmd_valid) begin
               accept_s       = 1'b1;
               cnt_load_s     = 1'b1;
               cnt_load_val_s = cmd_start;
               state_nx_s     = RUN;
            end else begin
               state_nx_s     = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               state_nx_s = IDLE;
            end else if (pause) begin
               state_nx_s = RUN;
            end else if (cnt_s != end_r) begin
               cnt_en_s   = 1'b1;
               state_nx_s = RUN;
            end else begin
               wrap_s = 1'b1;
               if (reps_left_r == REP_W'(1)) begin
                  state_nx_s = DONE;
               end else begin
                  reps_dec_s     = 1'b1;
                  cnt_load_s     = 1'b1;
                  cnt_load_val_s = start_r;
                  state_nx_s     = RUN;
               end
            end
         end
         DONE: begin
            state_nx_s = IDLE;
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Command field latches, captured only on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_r   <= DIR_DOWN;
         start_r <= '0;
         end_r   <= '0;
      end else if (accept_s) begin
         dir_r   <= cmd_dir;
         start_r <= cmd_start;
         end_r   <= cmd_end;
      end else begin
         dir_r   <= dir_r;
         start_r <= start_r;
         end_r   <= end_r;
      end
   end

   // Remaining-pass counter: loaded on accept, decremented at each non-final pass end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reps_left_r <= '0;
      end else if (accept_s) begin
         reps_left_r <= reps_norm_s;
      end else if (reps_dec_s) begin
         reps_left_r <= reps_left_r - REP_W'(1);
      end else begin
         reps_left_r <= reps_left_r;
      end
   end

   updown_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load_s),
      .load_val (cnt_load_val_s),
      .en       (cnt_en_s),
      .dir      (dir_r),
      .q        (cnt_s)
   );

   // cmd_ready is held low during reset even though the state already reads IDLE.
   assign cmd_ready = (state_r == IDLE) && !rst;
   assign busy      = (state_r == RUN) || (state_r == DONE);
   assign done      = (state_r == DONE);
   assign wrap      = wrap_s;
   assign cnt_out   = cnt_s;

endmodule : count_sequencer

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: reset, up/down passes, wrap-around,
// single-cycle passes, pause, abort and mid-run reset.
module tb_count_sequencer;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_dir;
   logic [7:0] cmd_start;
   logic [7:0] cmd_end;
   logic [3:0] cmd_reps;
   logic       pause;
   logic       abort;
   logic [7:0] cnt_out;
   logic       busy;
   logic       wrap;
   logic       done;

   int checks;
   int errors;

   count_sequencer #(.WIDTH(8), .REP_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dir   (cmd_dir),
      .cmd_start (cmd_start),
      .cmd_end   (cmd_end),
      .cmd_reps  (cmd_reps),
      .pause     (pause),
      .abort     (abort),
      .cnt_out   (cnt_out),
      .busy      (busy),
      .wrap      (wrap),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are driven after this point.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Present a command for one cycle and let it be accepted.
   task automatic send(input logic d, input int s, input int e, input int r);
      cmd_valid = 1'b1;
      cmd_dir   = d;
      cmd_start = 8'(s);
      cmd_end   = 8'(e);
      cmd_reps  = 4'(r);
      #1;
      check("ready_at_send", int'(cmd_ready), 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      int exp_cnt;
      int done_cyc;
      int wrap_cnt;
      int wrap_cyc;
      int done_cnt;
      int down_seq [8];

      checks    = 0;
      errors    = 0;
      cmd_valid = 1'b0;
      cmd_dir   = 1'b1;
      cmd_start = 8'd0;
      cmd_end   = 8'd0;
      cmd_reps  = 4'd0;
      pause     = 1'b0;
      abort     = 1'b0;
      rst       = 1'b1;

      // Reset state
      tick();
      #1;
      check("rst_ready", int'(cmd_ready), 0);
      check("rst_cnt",   int'(cnt_out), 0);
      check("rst_busy",  int'(busy), 0);
      check("rst_done",  int'(done), 0);
      check("rst_wrap",  int'(wrap), 0);
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_ready", int'(cmd_ready), 1);

      // Up 3->5, one pass
      send(1'b1, 3, 5, 1);
      for (int c = 1; c <= 5; c++) begin
         #1;
         if (c <= 3) begin
            check("up_cnt",  int'(cnt_out), c + 2);
            check("up_wrap", int'(wrap), (c == 3) ? 1 : 0);
            check("up_busy", int'(busy), 1);
         end else if (c == 4) begin
            check("up_done",     int'(done), 1);
            check("up_done_cnt", int'(cnt_out), 5);
            check("up_done_rdy", int'(cmd_ready), 0);
         end else begin
            check("up_idle_rdy",  int'(cmd_ready), 1);
            check("up_idle_done", int'(done), 0);
            check("up_idle_busy", int'(busy), 0);
            check("up_idle_hold", int'(cnt_out), 5);
         end
         if (c < 5) tick();
      end

      // Down 1->254 through zero, two passes
      down_seq = '{1, 0, 255, 254, 1, 0, 255, 254};
      send(1'b0, 1, 254, 2);
      wrap_cnt = 0;
      done_cnt = 0;
      done_cyc = -1;
      for (int c = 1; c <= 10; c++) begin
         #1;
         if (c <= 8) check("dn_cnt", int'(cnt_out), down_seq[c-1]);
         if (wrap) begin
            wrap_cnt++;
            check("dn_wrap_cyc", c % 4, 0);
         end
         if (done) begin
            done_cnt++;
            done_cyc = c;
         end
         tick();
      end
      check("dn_wraps",    wrap_cnt, 2);
      check("dn_dones",    done_cnt, 1);
      check("dn_done_cyc", done_cyc, 9);

      // Up 7->7 with reps=0: single one-cycle pass
      send(1'b1, 7, 7, 0);
      #1;
      check("one_cnt",  int'(cnt_out), 7);
      check("one_wrap", int'(wrap), 1);
      tick();
      #1;
      check("one_done", int'(done), 1);
      check("one_wrap2", int'(wrap), 0);
      tick();
      #1;
      check("one_idle", int'(cmd_ready), 1);

      // Up 0->9 with pause held for three cycles at cnt=4
      send(1'b1, 0, 9, 1);
      done_cyc = -1;
      wrap_cnt = 0;
      wrap_cyc = -1;
      for (int c = 1; c <= 16; c++) begin
         pause = (c >= 5 && c <= 7);
         #1;
         if (c <= 5)       exp_cnt = c - 1;
         else if (c <= 7)  exp_cnt = 4;
         else if (c <= 13) exp_cnt = c - 4;
         else              exp_cnt = 9;
         check("pz_cnt", int'(cnt_out), exp_cnt);
         if (wrap) begin
            wrap_cnt++;
            wrap_cyc = c;
         end
         if (done) done_cyc = c;
         tick();
      end
      pause = 1'b0;
      check("pz_wraps",    wrap_cnt, 1);
      check("pz_wrap_cyc", wrap_cyc, 13);
      check("pz_done_cyc", done_cyc, 14);

      // Abort+pause at cnt=6 with a competing command held during RUN
      send(1'b1, 0, 9, 1);
      done_cnt = 0;
      for (int c = 1; c <= 7; c++) begin
         if (c >= 2) begin
            cmd_valid = 1'b1;
            cmd_start = 8'd100;
            cmd_end   = 8'd101;
            cmd_reps  = 4'd1;
         end
         abort = (c == 7);
         pause = (c == 7);
         #1;
         check("ab_cnt", int'(cnt_out), c - 1);
         check("ab_rdy", int'(cmd_ready), 0);
         if (c == 7) check("ab_wrap", int'(wrap), 0);
         if (done) done_cnt++;
         tick();
      end
      abort = 1'b0;
      pause = 1'b0;
      #1;
      check("ab_idle_rdy",  int'(cmd_ready), 1);
      check("ab_idle_cnt",  int'(cnt_out), 6);
      check("ab_idle_done", int'(done), 0);
      check("ab_idle_busy", int'(busy), 0);
      check("ab_no_done",   done_cnt, 0);
      tick();
      cmd_valid = 1'b0;
      #1;
      check("ab_new_cnt",  int'(cnt_out), 100);
      check("ab_new_busy", int'(busy), 1);

      // Reset pulsed mid-RUN, then an immediate new command
      tick();
      #1;
      check("rr_pre_cnt", int'(cnt_out), 101);
      rst = 1'b1;
      #1;
      check("rr_cnt",  int'(cnt_out), 0);
      check("rr_busy", int'(busy), 0);
      check("rr_done", int'(done), 0);
      check("rr_rdy",  int'(cmd_ready), 0);
      tick();
      rst = 1'b0;
      #1;
      check("rr_done2", int'(done), 0);
      send(1'b1, 20, 21, 1);
      #1;
      check("rr_new_cnt", int'(cnt_out), 20);
      check("rr_new_busy", int'(busy), 1);
      tick();
      #1;
      check("rr_new_cnt2", int'(cnt_out), 21);
      check("rr_new_wrap", int'(wrap), 1);
      tick();
      #1;
      check("rr_new_done", int'(done), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_count_sequencer
